// File: rtl/cpu_div_cell.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, signed or unsigned,
// truncating division with the remainder taking the dividend's sign.
module cpu_div_cell #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] M_div_src1,
    input  logic [DATA_WIDTH-1:0] M_div_src2,
    input  logic                  M_div_start,
    input  logic                  M_div_signed,
    output logic                  M_div_busy,
    output logic                  M_div_done,
    output logic [DATA_WIDTH-1:0] M_div_cell_quotient,
    output logic [DATA_WIDTH-1:0] M_div_cell_remainder
);

    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DZ   = 2'd3;

    logic [1:0]            r_state;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_div;
    logic                  r_signed;
    logic                  r_qsign;
    logic                  r_rsign;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_quotient;
    logic [DATA_WIDTH-1:0] r_remainder;

    logic                  w_sign1;
    logic                  w_sign2;
    logic [DATA_WIDTH-1:0] w_mag1;
    logic [DATA_WIDTH-1:0] w_mag2;
    logic [DATA_WIDTH:0]   w_rem_shift;
    logic [DATA_WIDTH:0]   w_diff;
    logic [DATA_WIDTH-1:0] w_rem_next;
    logic [DATA_WIDTH-1:0] w_quo_fix;
    logic [DATA_WIDTH-1:0] w_rem_fix;

    // Magnitude of the most negative value wraps to itself, which is correct read as unsigned.
    assign w_sign1 = M_div_signed & M_div_src1[DATA_WIDTH-1];
    assign w_sign2 = M_div_signed & M_div_src2[DATA_WIDTH-1];
    assign w_mag1  = w_sign1 ? -M_div_src1 : M_div_src1;
    assign w_mag2  = w_sign2 ? -M_div_src2 : M_div_src2;

    // The extra difference bit catches the carry out of the shifted partial remainder.
    assign w_rem_shift = {r_rem, r_quo[DATA_WIDTH-1]};
    assign w_diff      = w_rem_shift - {1'b0, r_div};
    assign w_rem_next  = w_diff[DATA_WIDTH] ? w_rem_shift[DATA_WIDTH-1:0] : w_diff[DATA_WIDTH-1:0];

    assign w_quo_fix = (r_signed && r_qsign) ? -r_quo : r_quo;
    assign w_rem_fix = (r_signed && r_rsign) ? -r_rem : r_rem;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_div       <= '0;
            r_signed    <= 1'b0;
            r_qsign     <= 1'b0;
            r_rsign     <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (M_div_start) begin
                        r_signed <= M_div_signed;
                        r_qsign  <= w_sign1 ^ w_sign2;
                        r_rsign  <= w_sign1;
                        r_rem    <= '0;
                        r_cnt    <= CW'(DATA_WIDTH - 1);
                        if (M_div_src2 == '0) begin
                            r_quo   <= M_div_src1;
                            r_state <= S_DZ;
                        end else begin
                            r_quo   <= w_mag1;
                            r_div   <= w_mag2;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[DATA_WIDTH-2:0], ~w_diff[DATA_WIDTH]};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_quotient  <= w_quo_fix;
                    r_remainder <= w_rem_fix;
                    r_done      <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_DZ: begin
                    // Raw dividend was parked in the quotient register at acceptance.
                    r_quotient  <= '1;
                    r_remainder <= r_quo;
                    r_done      <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign M_div_busy           = (r_state != S_IDLE);
    assign M_div_done           = r_done;
    assign M_div_cell_quotient  = r_quotient;
    assign M_div_cell_remainder = r_remainder;

endmodule
